// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM states, command-byte
// field positions and the default identification value.
package spi_reg_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DISCARD
  } state_t;

  localparam int unsigned RW_BIT   = 7;
  localparam int unsigned ADDR_MSB = 6;

  localparam logic [7:0] ID_VALUE_DEF = 8'hA5;

endpackage

// File: rtl/spi_regfile.sv
// Register storage: one write port, combinational read, flat export.
// Register 0 is a constant identification byte and never stored.
module spi_regfile
  import spi_reg_bridge_pkg::*;
#(
  parameter int unsigned NREG     = 8,
  parameter logic [7:0]  ID_VALUE = ID_VALUE_DEF,
  parameter int unsigned AW       = 3
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [7:0]          i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [7:0]          o_rdata,
  output logic [8*NREG-1:0]   o_regs
);

  logic [8*NREG-1:0] w_flat;

  assign w_flat[7:0] = ID_VALUE;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_reg
      logic [7:0] r_reg;

      always_ff @(posedge sclk) begin
        if (!rst_n) begin
          r_reg <= '0;
        end else if (i_we && (i_waddr == AW'(g))) begin
          r_reg <= i_wdata;
        end
      end

      assign w_flat[8*g +: 8] = r_reg;
    end
  endgenerate

  assign o_regs  = w_flat;
  assign o_rdata = w_flat[{i_raddr, 3'b000} +: 8];

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level register bridge behind an SPI slave: parses a command byte,
// then streams writes into, or reads out of, an auto-incrementing address.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int unsigned NREG     = 8,
  parameter logic [7:0]  ID_VALUE = ID_VALUE_DEF
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic [7:0]          rx_data,
  input  logic                data_valid,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  output logic [8*NREG-1:0]   regs_out,
  output logic                wr_strobe,
  output logic                frame_err
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic          r_load;
  logic          w_load_nxt;
  logic          w_we;
  logic          w_wr_nxt;
  logic          w_ferr_nxt;
  logic [7:0]    w_rdata;
  logic          w_cmd_bad;

  assign w_cmd_bad = (32'(rx_data[ADDR_MSB:0]) >= NREG);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_load_nxt  = 1'b0;
    w_we        = 1'b0;
    w_wr_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;
    if (cs) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (data_valid) begin
            if (w_cmd_bad) begin
              w_state_nxt = ST_DISCARD;
              w_ferr_nxt  = 1'b1;
            end else begin
              w_addr_nxt = rx_data[AW-1:0];
              if (rx_data[RW_BIT]) begin
                w_state_nxt = ST_READ;
                w_load_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (data_valid) begin
            if (r_addr != '0) begin
              w_we     = 1'b1;
              w_wr_nxt = 1'b1;
            end
            w_addr_nxt = r_addr + 1'b1;
          end
        end
        ST_READ: begin
          if (data_valid) begin
            w_addr_nxt = r_addr + 1'b1;
            w_load_nxt = 1'b1;
          end
        end
        ST_DISCARD: begin
          w_state_nxt = ST_DISCARD;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // tx_data is fetched one edge after the address settles, so the read
  // port always sees the already-advanced r_addr.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_load    <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_load    <= w_load_nxt;
      wr_strobe <= w_wr_nxt;
      frame_err <= w_ferr_nxt;
      tx_start  <= r_load && !cs;
      if (r_load && !cs) begin
        tx_data <= w_rdata;
      end
    end
  end

  spi_regfile #(
    .NREG     (NREG),
    .ID_VALUE (ID_VALUE),
    .AW       (AW)
  ) u_regfile (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (rx_data),
    .i_raddr (r_addr),
    .o_rdata (w_rdata),
    .o_regs  (regs_out)
  );

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge (NREG=8, ID 0xA5).
module tb_spi_reg_bridge;

  logic        sclk;
  logic        rst_n;
  logic        cs;
  logic [7:0]  rx_data;
  logic        data_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [63:0] regs_out;
  logic        wr_strobe;
  logic        frame_err;

  int n_checks;
  int n_err;
  int wr_cnt;
  int wr_base;

  spi_reg_bridge #(
    .NREG     (8),
    .ID_VALUE (8'hA5)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .cs         (cs),
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .regs_out   (regs_out),
    .wr_strobe  (wr_strobe),
    .frame_err  (frame_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  function automatic logic [7:0] reg_at(input int i);
    return regs_out[8*i +: 8];
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    wr_cnt   = 0;
    rst_n = 1'b0; cs = 1'b1; rx_data = '0; data_valid = 1'b0;
    #1;
    tick(); tick();
    chk("rst_regs",   regs_out, 64'h0000_0000_0000_00A5);
    chk("rst_tx",     {56'h0, tx_data}, 64'h0);
    chk("rst_strobes", {61'h0, tx_start, wr_strobe, frame_err}, 64'h0);
    rst_n = 1'b1;
    tick();

    // write 0x03, 0x11, 0x22
    wr_base = wr_cnt;
    cs = 1'b0;
    send(8'h03);
    chk("w3_cmd_nostrobe", {63'h0, wr_strobe}, 64'h0);
    send(8'h11);
    chk("w3_strobe0", {63'h0, wr_strobe}, 64'h1);
    chk("w3_reg3", {56'h0, reg_at(3)}, 64'h11);
    send(8'h22);
    chk("w3_strobe1", {63'h0, wr_strobe}, 64'h1);
    chk("w3_reg4", {56'h0, reg_at(4)}, 64'h22);
    tick();
    chk("w3_strobe_off", {63'h0, wr_strobe}, 64'h0);
    cs = 1'b1; tick();
    chk("w3_count", 64'(wr_cnt - wr_base), 64'd2);

    // write 0x07, 0xAA, 0xBB: wrap into read-only reg 0
    wr_base = wr_cnt;
    cs = 1'b0;
    send(8'h07);
    send(8'hAA);
    chk("w7_reg7", {56'h0, reg_at(7)}, 64'hAA);
    send(8'hBB);
    chk("w7_wrap_nostrobe", {63'h0, wr_strobe}, 64'h0);
    chk("w7_reg0", {56'h0, reg_at(0)}, 64'hA5);
    cs = 1'b1; tick();
    chk("w7_count", 64'(wr_cnt - wr_base), 64'd1);

    // preload regs 1 and 2
    cs = 1'b0;
    send(8'h01); send(8'hCC); send(8'hDD);
    cs = 1'b1; tick();
    chk("pre_regs", regs_out, 64'hAA00_0022_11DD_CCA5);

    // read 0x80 then two dummy bytes
    cs = 1'b0;
    send(8'h80);
    chk("r0_cmd_nostart", {63'h0, tx_start}, 64'h0);
    tick();
    chk("r0_start", {63'h0, tx_start}, 64'h1);
    chk("r0_data", {56'h0, tx_data}, 64'hA5);
    send(8'h00);
    chk("r1_dummy_nostart", {63'h0, tx_start}, 64'h0);
    tick();
    chk("r1_start", {63'h0, tx_start}, 64'h1);
    chk("r1_data", {56'h0, tx_data}, 64'hCC);
    send(8'h00);
    tick();
    chk("r2_start", {63'h0, tx_start}, 64'h1);
    chk("r2_data", {56'h0, tx_data}, 64'hDD);
    tick();
    chk("r2_start_off", {63'h0, tx_start}, 64'h0);
    cs = 1'b1; tick();

    // bad address 0x0A -> discard
    wr_base = wr_cnt;
    cs = 1'b0;
    send(8'h0A);
    chk("bad_ferr", {63'h0, frame_err}, 64'h1);
    send(8'h55);
    chk("bad_ferr_off", {63'h0, frame_err}, 64'h0);
    send(8'h66);
    chk("bad_no_write", regs_out, 64'hAA00_0022_11DD_CCA5);
    cs = 1'b1; tick();
    chk("bad_count", 64'(wr_cnt - wr_base), 64'd0);
    cs = 1'b0;
    send(8'h02); send(8'h5C);
    chk("bad_recover_reg2", {56'h0, reg_at(2)}, 64'h5C);
    cs = 1'b1; tick();
    chk("bad_all_regs", regs_out, 64'hAA00_0022_115C_CCA5);

    // read wrap 0x87 -> regs[7], then regs[0]
    cs = 1'b0;
    send(8'h87);
    tick();
    chk("rw_data7", {56'h0, tx_data}, 64'hAA);
    send(8'h00);
    tick();
    chk("rw_start0", {63'h0, tx_start}, 64'h1);
    chk("rw_data0", {56'h0, tx_data}, 64'hA5);
    cs = 1'b1; tick();

    // cs high on the same edge as data_valid in WRITE
    cs = 1'b0;
    send(8'h05);
    cs = 1'b1;
    send(8'h77);
    chk("cs_nowrite_strobe", {63'h0, wr_strobe}, 64'h0);
    chk("cs_nowrite_reg5", {56'h0, reg_at(5)}, 64'h00);
    cs = 1'b0;
    send(8'h99);
    chk("cs_idle_reparse", {63'h0, frame_err}, 64'h1);
    cs = 1'b1; tick();

    // reset mid-write, then write 0x01, 0x33 with cs still low
    cs = 1'b0;
    send(8'h03); send(8'h44);
    chk("mr_reg3", {56'h0, reg_at(3)}, 64'h44);
    rst_n = 1'b0;
    tick();
    chk("mr_cleared", regs_out, 64'h0000_0000_0000_00A5);
    chk("mr_outs", {48'h0, tx_data, 5'h0, tx_start, wr_strobe, frame_err}, 64'h0);
    rst_n = 1'b1;
    send(8'h01);
    chk("mr_cmd_nostrobe", {63'h0, wr_strobe}, 64'h0);
    send(8'h33);
    chk("mr_strobe", {63'h0, wr_strobe}, 64'h1);
    chk("mr_regs", regs_out, 64'h0000_0000_0000_33A5);
    cs = 1'b1; tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
